// File: rtl/gsim_pkg.sv
// Shared definitions for the GSIM controller and update datapath.
package gsim_pkg;

  // Problem size
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 10;

  // Q16.16 number format
  localparam int unsigned FRAC = 16;
  localparam int unsigned XW   = 32;
  localparam int unsigned BW   = 16;

  // Band coefficients: x[r] = (b + 13*(r+-1) - 6*(r+-2) + 1*(r+-3)) / 20
  localparam int unsigned COEF_DIAG = 20;
  localparam int unsigned COEF_B1   = 13;
  localparam int unsigned COEF_B2   = 6;
  localparam int unsigned COEF_B3   = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/gsim_ctrl.sv
// Sequencer for the GSIM: loads b, schedules N_ITER sweeps of row updates,
// then streams the solution out of the datapath x register file.
module gsim_ctrl
  import gsim_pkg::*;
#(
  parameter int unsigned N_ITER = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_en,
  output logic          b_we,
  output logic [AW-1:0] b_waddr,
  output logic          x_clr,
  output logic          upd_start,
  output logic [AW-1:0] upd_row,
  input  logic          upd_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          out_valid,
  output logic [IW-1:0] iter_cnt,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_ROW  = AW'(N - 1);
  localparam logic [IW-1:0] LAST_ITER = IW'(N_ITER - 1);

  state_e        state;
  logic [AW-1:0] load_cnt;

  // b write port and x clear follow in_en in the same cycle so no word is lost
  always_comb begin
    b_we    = 1'b0;
    b_waddr = '0;
    x_clr   = 1'b0;
    if (state == IDLE) begin
      b_we = in_en;
    end else if (state == LOAD) begin
      b_we    = in_en;
      b_waddr = load_cnt;
      x_clr   = in_en && (load_cnt == LAST_ROW);
    end
  end

  // FSM, counters and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      load_cnt  <= '0;
      upd_row   <= '0;
      iter_cnt  <= '0;
      rd_addr   <= '0;
      upd_start <= 1'b0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      upd_start <= 1'b0;
      out_valid <= rd_en;
      case (state)
        IDLE: begin
          if (in_en) begin
            state    <= LOAD;
            load_cnt <= AW'(1);
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_en) begin
            if (load_cnt == LAST_ROW) begin
              state     <= ISSUE;
              load_cnt  <= '0;
              upd_row   <= '0;
              iter_cnt  <= '0;
              upd_start <= 1'b1;
            end else begin
              load_cnt <= load_cnt + AW'(1);
            end
          end
        end
        // upd_start is high for this single cycle; upd_done here is stale
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (upd_done) begin
            if (upd_row != LAST_ROW) begin
              upd_row   <= upd_row + AW'(1);
              state     <= ISSUE;
              upd_start <= 1'b1;
            end else if (iter_cnt != LAST_ITER) begin
              upd_row   <= '0;
              iter_cnt  <= iter_cnt + IW'(1);
              state     <= ISSUE;
              upd_start <= 1'b1;
            end else begin
              state   <= OUT;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        OUT: begin
          if (rd_addr == LAST_ROW) begin
            state   <= IDLE;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          rd_en     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_ctrl.sv
// Scoreboard bench for gsim_ctrl with a latency-programmable datapath stub.
module tb_gsim_ctrl;
  import gsim_pkg::*;

  localparam int unsigned NI    = 2;
  localparam int          GUARD = 20000;

  logic          clk;
  logic          reset;
  logic          in_en;
  logic          b_we;
  logic [AW-1:0] b_waddr;
  logic          x_clr;
  logic          upd_start;
  logic [AW-1:0] upd_row;
  logic          upd_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic [IW-1:0] iter_cnt;
  logic          busy;
  logic [XW-1:0] x_out;

  gsim_ctrl #(.N_ITER(NI)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .b_we      (b_we),
    .b_waddr   (b_waddr),
    .x_clr     (x_clr),
    .upd_start (upd_start),
    .upd_row   (upd_row),
    .upd_done  (upd_done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .iter_cnt  (iter_cnt),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int stub_l = 3;
  logic kick_done = 1'b0;

  // expected-response queues
  int exp_waddr[$];
  int exp_row[$];
  int exp_iter[$];
  int exp_rd[$];
  logic [XW-1:0] exp_dat[$];

  int last_word_cyc = 0;
  int prev_upd_cyc  = 0;
  bit first_upd_pending = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // datapath stub: fixed update latency, one-cycle x read, stray upd_done pulses
  int stub_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      stub_cnt = 0;
      upd_done = 1'b0;
    end else begin
      upd_done = kick_done;
      if (upd_start) begin
        stub_cnt = stub_l;
        if ($urandom_range(0, 2) == 0) upd_done = 1'b1;
      end else if (stub_cnt > 0) begin
        stub_cnt = stub_cnt - 1;
        if (stub_cnt == 0) upd_done = 1'b1;
      end else if ($urandom_range(0, 5) == 0) begin
        upd_done = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rd_en) x_out <= XW'(rd_addr) << FRAC;
  end

  // monitor: pop expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (reset) begin
      if (b_we) begin
        if (exp_waddr.size() == 0) begin
          check("b_we_unexpected", 32'(b_we), 32'd0);
        end else begin
          int e;
          e = exp_waddr.pop_front();
          check("b_waddr", 32'(b_waddr), 32'(e));
          check("x_clr_with_word", 32'(x_clr), 32'(e == int'(N) - 1));
          if (e == int'(N) - 1) begin
            last_word_cyc = cyc;
            first_upd_pending = 1'b1;
          end
        end
      end else if (x_clr) begin
        check("x_clr_without_word", 32'(x_clr), 32'd0);
      end

      if (upd_start) begin
        if (exp_row.size() == 0) begin
          check("upd_start_unexpected", 32'(upd_start), 32'd0);
        end else begin
          int r;
          int it;
          r  = exp_row.pop_front();
          it = exp_iter.pop_front();
          check("upd_row", 32'(upd_row), 32'(r));
          check("iter_cnt", 32'(iter_cnt), 32'(it));
          if (first_upd_pending)
            check("first_upd_delay", 32'(cyc - last_word_cyc), 32'd1);
          else
            check("upd_spacing", 32'(cyc - prev_upd_cyc), 32'(stub_l + 1));
          first_upd_pending = 1'b0;
          prev_upd_cyc = cyc;
        end
      end

      if (rd_en) begin
        if (exp_rd.size() == 0) begin
          check("rd_en_unexpected", 32'(rd_en), 32'd0);
        end else begin
          int a;
          a = exp_rd.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(a));
          if (a == int'(N) - 1) check("busy_last_rd", 32'(busy), 32'd1);
        end
      end

      if (out_valid) begin
        if (exp_dat.size() == 0) begin
          check("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          logic [XW-1:0] d;
          d = exp_dat.pop_front();
          check("x_out", x_out, d);
          if (d == '0)
            check("out_latency", 32'(cyc - last_word_cyc),
                  32'(int'(N) * int'(NI) * (stub_l + 1) + 2));
          if (d == (XW'(N - 1) << FRAC)) check("busy_after_out", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_b_we"}, 32'(b_we), 32'd0);
    check({tag, "_b_waddr"}, 32'(b_waddr), 32'd0);
    check({tag, "_x_clr"}, 32'(x_clr), 32'd0);
    check({tag, "_upd_start"}, 32'(upd_start), 32'd0);
    check({tag, "_upd_row"}, 32'(upd_row), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_iter_cnt"}, 32'(iter_cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // reference behaviour of one job: N writes, N*NI ordered updates, N reads
  task automatic push_expect();
    for (int k = 0; k < int'(N); k++) exp_waddr.push_back(k);
    for (int it = 0; it < int'(NI); it++)
      for (int r = 0; r < int'(N); r++) begin
        exp_row.push_back(r);
        exp_iter.push_back(it);
      end
    for (int k = 0; k < int'(N); k++) begin
      exp_rd.push_back(k);
      exp_dat.push_back(XW'(k) << FRAC);
    end
  endtask

  task automatic drive_load(input int gap_after, input int gap_len, input bit rand_gaps);
    for (int k = 0; k < int'(N); k++) begin
      in_en = 1'b1;
      @(posedge clk); #1;
      in_en = 1'b0;
      if (k == gap_after) begin
        repeat (gap_len) begin @(posedge clk); #1; end
      end else if (rand_gaps && k != int'(N) - 1) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
  endtask

  // sweep phase with stray in_en, then drain to the first IDLE cycle
  task automatic finish_job();
    int g;
    g = 0;
    while (!rd_en && g < GUARD) begin
      in_en = ($urandom_range(0, 4) == 0);
      @(posedge clk); #1;
      g++;
    end
    in_en = 1'b0;
    while (busy && g < GUARD) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= GUARD) check("job_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_job(input int l, input int gap_after, input int gap_len, input bit rand_gaps);
    stub_l = l;
    push_expect();
    drive_load(gap_after, gap_len, rand_gaps);
    finish_job();
  endtask

  task automatic reset_mid_issue();
    int g;
    stub_l = 3;
    push_expect();
    drive_load(-1, 0, 1'b0);
    g = 0;
    while (!(upd_start && upd_row == AW'(4)) && g < GUARD) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= GUARD) check("reset_wait_timeout", 32'd1, 32'd0);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    exp_waddr.delete();
    exp_row.delete();
    exp_iter.delete();
    exp_rd.delete();
    exp_dat.delete();
    first_upd_pending = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    kick_done = 1'b1;
    @(posedge clk); #1;
    kick_done = 1'b0;
    repeat (4) begin
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_upd_start", 32'(upd_start), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    in_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_init");
    reset = 1'b1;
    @(posedge clk); #1;

    run_job(3, -1, 0, 1'b0);
    run_job(3, 5, 3, 1'b0);
    reset_mid_issue();
    run_job(1, -1, 0, 1'b1);
    run_job(int'($urandom_range(2, 5)), -1, 0, 1'b1);
    run_job(3, -1, 0, 1'b0);

    repeat (4) begin @(posedge clk); #1; end
    check("queues_drained",
          32'(exp_waddr.size() + exp_row.size() + exp_rd.size() + exp_dat.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
